// File: rtl/exu_csr_ctrl_if.sv
// CSR access bus between the EXU decode/commit logic and exu_csr_ctrl.
// The master issues read/write requests; the slave (CSR unit) returns the
// pre-write value and an illegal-access flag combinationally.
interface exu_csr_ctrl_if;
    logic        csr_wen;
    logic        csr_ren;
    logic [1:0]  csr_op;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdat;
    logic [31:0] csr_rdat;
    logic        csr_ill;

    modport master (
        output csr_wen, csr_ren, csr_op, csr_idx, csr_wdat,
        input  csr_rdat, csr_ill
    );

    modport slave (
        input  csr_wen, csr_ren, csr_op, csr_idx, csr_wdat,
        output csr_rdat, csr_ill
    );
endinterface

// File: rtl/exu_csr_ctrl.sv
// Machine-mode CSR unit: internal read-modify-write, trap/mret state update,
// 64-bit mcycle/minstret plus NUM_HPM event counters, trap vector target and
// prioritised interrupt request.
// Optional macro CSR_VECTORED_EN: makes mtvec[0] writable and enables
// vectored interrupt targets (base + 4*cause).
module exu_csr_ctrl #(
    parameter int          NUM_HPM = 4,
    parameter logic [31:0] MIMPID  = 32'h0000c10a
) (
    input  logic               clk,
    input  logic               rst_n,
    exu_csr_ctrl_if.slave      csr,
    input  logic               trap_ena,
    input  logic [31:0]        trap_cause,
    input  logic [31:0]        trap_tval,
    input  logic [31:0]        trap_pc,
    input  logic               mret_ena,
    output logic [31:0]        trap_tgt,
    output logic [31:0]        cmepc,
    input  logic               ext_ip,
    input  logic               tmr_ip,
    input  logic               sft_ip,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    input  logic               in_retr,
    input  logic [NUM_HPM-1:0] hpm_evt
);
    // counter slot n sits at 0xB00+n / 0xB80+n; slot 1 (time) is absent
    localparam int          NCNT     = 3 + NUM_HPM;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic        mie_b, mpie;
    logic [31:0] mie_r, mtvec, mscratch, mepc, mcause, mtval, minh;
    logic        ip_e, ip_t, ip_s;
    logic [63:0] cnt_q [NCNT];

    logic        cnt_sel, impl, wr_go;
    logic [63:0] cnt_rd;
    logic [31:0] rdat_raw, wnew, mip_v, pend;

    assign mip_v = {20'b0, ip_e, 3'b0, ip_t, 3'b0, ip_s, 3'b0};
    assign pend  = mip_v & mie_r;

    assign cnt_sel = (csr.csr_idx[11:8] == 4'hB) && (csr.csr_idx[6:5] == 2'b00) &&
                     (csr.csr_idx[4:0] != 5'd1) &&
                     ({27'b0, csr.csr_idx[4:0]} < 32'(NCNT));

    // select the addressed counter slot
    always_comb begin
        cnt_rd = '0;
        for (int k = 0; k < NCNT; k++)
            if (csr.csr_idx[4:0] == 5'(k)) cnt_rd = cnt_q[k];
    end

    // address decode and raw (pre-write) read value
    always_comb begin
        impl     = 1'b1;
        rdat_raw = '0;
        case (csr.csr_idx)
            12'h300: rdat_raw = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_b, 3'b0};
            12'h301: rdat_raw = 32'h40000100;
            12'h304: rdat_raw = mie_r;
            12'h305: rdat_raw = mtvec;
            12'h320: rdat_raw = minh;
            12'h340: rdat_raw = mscratch;
            12'h341: rdat_raw = mepc;
            12'h342: rdat_raw = mcause;
            12'h343: rdat_raw = mtval;
            12'h344: rdat_raw = mip_v;
            12'hF11, 12'hF12, 12'hF14: rdat_raw = '0;
            12'hF13: rdat_raw = MIMPID;
            default: begin
                if (cnt_sel) rdat_raw = csr.csr_idx[7] ? cnt_rd[63:32] : cnt_rd[31:0];
                else         impl     = 1'b0;
            end
        endcase
    end

    // read-modify-write operand
    always_comb begin
        wnew = rdat_raw;
        case (csr.csr_op)
            2'b01:   wnew = csr.csr_wdat;
            2'b10:   wnew = rdat_raw | csr.csr_wdat;
            2'b11:   wnew = rdat_raw & ~csr.csr_wdat;
            default: wnew = rdat_raw;
        endcase
    end

    assign csr.csr_ill  = (csr.csr_ren | csr.csr_wen) &
                          (~impl | (csr.csr_wen & (csr.csr_idx[11:10] == 2'b11)));
    assign csr.csr_rdat = (csr.csr_ren & impl) ? rdat_raw : '0;

    // a trap in the same cycle swallows the CSR write
    assign wr_go = csr.csr_wen & (csr.csr_op != 2'b00) & ~csr.csr_ill & ~trap_ena;

    // trap entry, mret and plain CSR writes; mret overrides a same-cycle mstatus write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_b <= 1'b0;  mpie <= 1'b0;
            mie_r <= '0;    mtvec <= '0;   mscratch <= '0; mepc <= '0;
            mcause <= '0;   mtval <= '0;   minh <= '0;
            ip_e <= 1'b0;   ip_t <= 1'b0;  ip_s <= 1'b0;
        end else begin
            ip_e <= ext_ip;
            ip_t <= tmr_ip;
            ip_s <= sft_ip;
            if (trap_ena) begin
                mepc   <= trap_pc & ~32'h1;
                mcause <= trap_cause;
                mtval  <= trap_tval;
                mpie   <= mie_b;
                mie_b  <= 1'b0;
            end else begin
                if (wr_go) begin
                    case (csr.csr_idx)
                        12'h300: begin mie_b <= wnew[3]; mpie <= wnew[7]; end
                        12'h304: mie_r    <= wnew & 32'h888;
`ifdef CSR_VECTORED_EN
                        12'h305: mtvec    <= {wnew[31:2], 1'b0, wnew[1] ? 1'b0 : wnew[0]};
`else
                        12'h305: mtvec    <= {wnew[31:2], 2'b00};
`endif
                        12'h320: minh     <= wnew & INH_MASK;
                        12'h340: mscratch <= wnew;
                        12'h341: mepc     <= wnew & ~32'h1;
                        12'h342: mcause   <= wnew;
                        12'h343: mtval    <= wnew;
                        default: ;
                    endcase
                end
                if (mret_ena) begin
                    mie_b <= mpie;
                    mpie  <= 1'b1;
                end
            end
        end
    end

    // one 64-bit counter per slot; a high-half write drops the low-half carry
    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        if (g == 1) begin : g_none
            assign cnt_q[g] = '0;
        end else begin : g_ctr
            logic        inc;
            logic [63:0] q;
            if (g == 0) begin : g_cy
                assign inc = ~minh[0];
            end else if (g == 2) begin : g_ir
                assign inc = in_retr & ~minh[2];
            end else begin : g_hpm
                assign inc = hpm_evt[g-3] & ~minh[g];
            end
            // count, or load one half on a CSR write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= '0;
                else if (wr_go && cnt_sel && (csr.csr_idx[4:0] == 5'(g))) begin
                    if (csr.csr_idx[7]) q <= {wnew, q[31:0] + {31'b0, inc}};
                    else                q <= {q[63:32], wnew};
                end else
                    q <= q + {63'b0, inc};
            end
            assign cnt_q[g] = q;
        end
    end

    // trap target: direct base, or vectored offset for interrupts
    always_comb begin
        trap_tgt = {mtvec[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
        if (mtvec[0] && trap_cause[31])
            trap_tgt = {mtvec[31:2], 2'b00} + {25'b0, trap_cause[4:0], 2'b00};
`endif
    end

    assign cmepc = mepc;

    // interrupt priority MEI > MSI > MTI
    always_comb begin
        irq_req   = mie_b & (|pend);
        irq_cause = '0;
        if (irq_req) begin
            if (pend[11])     irq_cause = 32'h8000000B;
            else if (pend[3]) irq_cause = 32'h80000003;
            else              irq_cause = 32'h80000007;
        end
    end
endmodule

// File: tb/tb_exu_csr_ctrl.sv
// Self-checking bench for exu_csr_ctrl: directed scenarios plus a randomized
// run checked against a behavioural CSR model.
module tb_exu_csr_ctrl;
    localparam int NHPM = 4;
    localparam logic [31:0] INH = 32'h5 | (((32'h1 << NHPM) - 32'h1) << 3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exu_csr_ctrl_if bus ();
    logic            trap_ena, mret_ena, ext_ip, tmr_ip, sft_ip, in_retr;
    logic [31:0]     trap_cause, trap_tval, trap_pc;
    logic [NHPM-1:0] hpm_evt;
    logic [31:0]     trap_tgt, cmepc, irq_cause;
    logic            irq_req;

    int vec_cnt = 0;
    int err_cnt = 0;

    exu_csr_ctrl #(.NUM_HPM(NHPM)) dut (
        .clk(clk), .rst_n(rst_n), .csr(bus),
        .trap_ena(trap_ena), .trap_cause(trap_cause), .trap_tval(trap_tval),
        .trap_pc(trap_pc), .mret_ena(mret_ena), .trap_tgt(trap_tgt), .cmepc(cmepc),
        .ext_ip(ext_ip), .tmr_ip(tmr_ip), .sft_ip(sft_ip),
        .irq_req(irq_req), .irq_cause(irq_cause),
        .in_retr(in_retr), .hpm_evt(hpm_evt)
    );

    // ---------------- behavioural model ----------------
    logic        m_mie, m_mpie;
    logic [31:0] m_mier, m_mtvec, m_mscr, m_mepc, m_mcause, m_mtval, m_inh;
    logic [2:0]  m_ip;                // {ext, tmr, sft} as seen last edge
    logic [63:0] m_cnt [32];

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = 0; m_mscr = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_inh = 0; m_ip = 0;
        for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    endtask

    function automatic logic [31:0] m_mip();
        return (32'(m_ip[2]) << 11) | (32'(m_ip[1]) << 7) | (32'(m_ip[0]) << 3);
    endfunction

    // {implemented, value}
    function automatic logic [32:0] m_rd(input logic [11:0] a);
        logic [4:0] n;
        n = a[4:0];
        case (a)
            12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
            12'h301: return {1'b1, 32'h40000100};
            12'h304: return {1'b1, m_mier};
            12'h305: return {1'b1, m_mtvec};
            12'h320: return {1'b1, m_inh};
            12'h340: return {1'b1, m_mscr};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip()};
            12'hF11, 12'hF12, 12'hF14: return {1'b1, 32'h0};
            12'hF13: return {1'b1, 32'h0000c10a};
            default: begin
                if ((a[11:7] == 5'b10110 || a[11:7] == 5'b10111) && a[6:5] == 2'b00 &&
                    n != 5'd1 && int'(n) < 3 + NHPM)
                    return {1'b1, a[7] ? m_cnt[n][63:32] : m_cnt[n][31:0]};
                return 33'd0;
            end
        endcase
    endfunction

    function automatic logic m_ill();
        logic [32:0] r;
        logic [11:0] a;
        r = m_rd(bus.csr_idx);
        a = bus.csr_idx;
        return (bus.csr_ren || bus.csr_wen) && (!r[32] || (bus.csr_wen && a[11:10] == 2'b11));
    endfunction

    function automatic logic [31:0] m_tgt();
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
`ifdef CSR_VECTORED_EN
        if (m_mtvec[0] && trap_cause[31]) return base + 32'(trap_cause[4:0]) * 32'd4;
`endif
        return base;
    endfunction

    // advance the model across one clock edge using the current inputs
    task automatic m_step();
        logic [32:0] r;
        logic [31:0] old, nv, lo;
        logic [11:0] a;
        logic        wr, inc, old_mpie;
        logic [63:0] c;
        a   = bus.csr_idx;
        r   = m_rd(a);
        old = r[31:0];
        wr  = bus.csr_wen && bus.csr_op != 2'b00 && !m_ill() && !trap_ena;
        case (bus.csr_op)
            2'b01:   nv = bus.csr_wdat;
            2'b10:   nv = old | bus.csr_wdat;
            2'b11:   nv = old & ~bus.csr_wdat;
            default: nv = old;
        endcase
        for (int n = 0; n < 3 + NHPM; n++) begin
            if (n == 1) continue;
            if (n == 0)      inc = !m_inh[0];
            else if (n == 2) inc = in_retr && !m_inh[2];
            else             inc = hpm_evt[n-3] && !m_inh[n];
            c = m_cnt[n];
            if (wr && a[11:8] == 4'hB && int'(a[4:0]) == n) begin
                lo = c[31:0] + 32'(inc);
                c  = a[7] ? {nv, lo} : {c[63:32], nv};
            end else
                c = c + 64'(inc);
            m_cnt[n] = c;
        end
        old_mpie = m_mpie;
        if (trap_ena) begin
            m_mepc = trap_pc & ~32'h1; m_mcause = trap_cause; m_mtval = trap_tval;
            m_mpie = m_mie; m_mie = 0;
        end else begin
            if (wr) case (a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mier = nv & 32'h888;
`ifdef CSR_VECTORED_EN
                12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : (nv & ~32'h2);
`else
                12'h305: m_mtvec = nv & ~32'h3;
`endif
                12'h320: m_inh = nv & INH;
                12'h340: m_mscr = nv;
                12'h341: m_mepc = nv & ~32'h1;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                default: ;
            endcase
            if (mret_ena) begin m_mie = old_mpie; m_mpie = 1; end
        end
        m_ip = {ext_ip, tmr_ip, sft_ip};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic ren, input logic [1:0] op,
                         input logic [11:0] idx, input logic [31:0] wdat);
        bus.csr_wen = wen; bus.csr_ren = ren; bus.csr_op = op;
        bus.csr_idx = idx; bus.csr_wdat = wdat;
        #1;
    endtask

    task automatic idle();
        trap_ena = 0; mret_ena = 0; ext_ip = 0; tmr_ip = 0; sft_ip = 0; in_retr = 0;
        trap_cause = 0; trap_tval = 0; trap_pc = 0; hpm_evt = '0;
        bus.csr_wen = 0; bus.csr_ren = 0; bus.csr_op = 0; bus.csr_idx = 0; bus.csr_wdat = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(); do_reset();
        drive(0, 1, 0, 12'h301, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h40000100) begin err_cnt++; $display("FAIL reset_misa got %h exp 40000100", bus.csr_rdat); end
        drive(0, 1, 0, 12'h300, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h00001800) begin err_cnt++; $display("FAIL reset_mstatus got %h exp 00001800", bus.csr_rdat); end
        drive(0, 1, 0, 12'hB00, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0 || bus.csr_ill !== 1'b0) begin err_cnt++; $display("FAIL reset_mcycle got %h ill %b exp 0 ill 0", bus.csr_rdat, bus.csr_ill); end
        vec_cnt++; if (irq_req !== 1'b0 || irq_cause !== 32'h0 || cmepc !== 32'h0 || trap_tgt !== 32'h0) begin err_cnt++; $display("FAIL reset_outs got req %b cause %h mepc %h tgt %h exp all 0", irq_req, irq_cause, cmepc, trap_tgt); end
        drive(0, 1, 0, 12'h340, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL reset_mscratch got %h exp 0", bus.csr_rdat); end
        tick();
        drive(0, 1, 0, 12'hB00, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h1) begin err_cnt++; $display("FAIL mcycle_first_inc got %h exp 1", bus.csr_rdat); end
        drive(0, 0, 0, 12'h301, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL rdat_no_ren got %h exp 0", bus.csr_rdat); end
    endtask

    task automatic test_rmw();
        idle(); do_reset();
        drive(1, 1, 1, 12'h340, 32'hF0F0F0F0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL rmw_rw_old got %h exp 0", bus.csr_rdat); end
        tick(); drive(1, 1, 2, 12'h340, 32'h0000000F);
        vec_cnt++; if (bus.csr_rdat !== 32'hF0F0F0F0) begin err_cnt++; $display("FAIL rmw_rs_old got %h exp F0F0F0F0", bus.csr_rdat); end
        tick(); drive(1, 1, 3, 12'h340, 32'h000000F0);
        vec_cnt++; if (bus.csr_rdat !== 32'hF0F0F0FF) begin err_cnt++; $display("FAIL rmw_rc_old got %h exp F0F0F0FF", bus.csr_rdat); end
        tick(); drive(0, 1, 0, 12'h340, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'hF0F0F00F) begin err_cnt++; $display("FAIL rmw_final got %h exp F0F0F00F", bus.csr_rdat); end
        drive(1, 0, 1, 12'h341, 32'h12345677); tick();
        vec_cnt++; if (cmepc !== 32'h12345676) begin err_cnt++; $display("FAIL mepc_bit0 got %h exp 12345676", cmepc); end
        drive(1, 0, 1, 12'h304, 32'hFFFFFFFF); tick(); drive(0, 1, 0, 12'h304, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h888) begin err_cnt++; $display("FAIL mie_mask got %h exp 888", bus.csr_rdat); end
        drive(1, 0, 1, 12'h320, 32'hFFFFFFFF); tick(); drive(0, 1, 0, 12'h320, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h7D) begin err_cnt++; $display("FAIL inhibit_mask got %h exp 7D", bus.csr_rdat); end
        drive(1, 0, 1, 12'h300, 32'hFFFFFFFF); tick(); drive(0, 1, 0, 12'h300, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h1888) begin err_cnt++; $display("FAIL mstatus_mask got %h exp 1888", bus.csr_rdat); end
        drive(1, 0, 1, 12'h344, 32'hFFFFFFFF);
        vec_cnt++; if (bus.csr_ill !== 1'b0) begin err_cnt++; $display("FAIL mip_write_legal got ill %b exp 0", bus.csr_ill); end
        tick(); drive(0, 1, 0, 12'h344, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL mip_readonly got %h exp 0", bus.csr_rdat); end
    endtask

    task automatic test_illegal();
        logic [11:0] ill_idx [6];
        logic [11:0] ok_idx  [4];
        ill_idx = '{12'hFC0, 12'h7C0, 12'hB01, 12'hB07, 12'h323, 12'hC00};
        ok_idx  = '{12'hF13, 12'hB06, 12'hB86, 12'h343};
        idle(); do_reset();
        foreach (ill_idx[i]) begin
            drive(1, 1, 1, ill_idx[i], 32'h1);
            vec_cnt++; if (bus.csr_ill !== 1'b1 || bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL ill_unimpl idx %h got ill %b rdat %h exp 1/0", ill_idx[i], bus.csr_ill, bus.csr_rdat); end
        end
        foreach (ok_idx[i]) begin
            drive(0, 1, 0, ok_idx[i], 0);
            vec_cnt++; if (bus.csr_ill !== 1'b0) begin err_cnt++; $display("FAIL ill_read_ok idx %h got %b exp 0", ok_idx[i], bus.csr_ill); end
        end
        drive(0, 1, 0, 12'hF13, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0000c10a) begin err_cnt++; $display("FAIL mimpid got %h exp 0000c10a", bus.csr_rdat); end
        drive(1, 0, 0, 12'hF11, 0);
        vec_cnt++; if (bus.csr_ill !== 1'b1) begin err_cnt++; $display("FAIL ill_ro_write got %b exp 1", bus.csr_ill); end
        drive(0, 0, 1, 12'hFC0, 0);
        vec_cnt++; if (bus.csr_ill !== 1'b0) begin err_cnt++; $display("FAIL ill_no_access got %b exp 0", bus.csr_ill); end
    endtask

    task automatic test_irq();
        idle(); do_reset();
        drive(1, 0, 2, 12'h300, 32'h8); tick();
        drive(1, 0, 1, 12'h304, 32'h888); tick();
        drive(0, 0, 0, 12'h0, 0);
        tmr_ip = 1; sft_ip = 1; #1;
        vec_cnt++; if (irq_req !== 1'b0) begin err_cnt++; $display("FAIL irq_latency got %b exp 0", irq_req); end
        tick();
        vec_cnt++; if (irq_req !== 1'b1 || irq_cause !== 32'h80000003) begin err_cnt++; $display("FAIL irq_msi got %b %h exp 1 80000003", irq_req, irq_cause); end
        drive(0, 1, 0, 12'h344, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h88) begin err_cnt++; $display("FAIL mip_read got %h exp 88", bus.csr_rdat); end
        sft_ip = 0; tick();
        vec_cnt++; if (irq_cause !== 32'h80000007) begin err_cnt++; $display("FAIL irq_mti got %h exp 80000007", irq_cause); end
        ext_ip = 1; sft_ip = 1; tick();
        vec_cnt++; if (irq_cause !== 32'h8000000B) begin err_cnt++; $display("FAIL irq_mei got %h exp 8000000B", irq_cause); end
        drive(1, 0, 1, 12'h304, 32'h080); tick();
        vec_cnt++; if (irq_cause !== 32'h80000007) begin err_cnt++; $display("FAIL irq_masked got %h exp 80000007", irq_cause); end
        drive(1, 0, 3, 12'h300, 32'h8); tick();
        vec_cnt++; if (irq_req !== 1'b0 || irq_cause !== 32'h0) begin err_cnt++; $display("FAIL irq_mie_off got %b %h exp 0 0", irq_req, irq_cause); end
        idle();
    endtask

    task automatic test_trap();
        idle(); do_reset();
        drive(1, 0, 2, 12'h300, 32'h8); tick();
        trap_ena = 1; trap_pc = 32'h103; trap_cause = 32'h80000007; trap_tval = 32'hDEAD;
        drive(1, 1, 1, 12'h340, 32'h1234); tick();
        trap_ena = 0;
        drive(0, 1, 0, 12'h341, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h102 || cmepc !== 32'h102) begin err_cnt++; $display("FAIL trap_mepc got %h/%h exp 102", bus.csr_rdat, cmepc); end
        drive(0, 1, 0, 12'h342, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h80000007) begin err_cnt++; $display("FAIL trap_mcause got %h exp 80000007", bus.csr_rdat); end
        drive(0, 1, 0, 12'h343, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'hDEAD) begin err_cnt++; $display("FAIL trap_mtval got %h exp DEAD", bus.csr_rdat); end
        drive(0, 1, 0, 12'h300, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h1880) begin err_cnt++; $display("FAIL trap_mstatus got %h exp 1880", bus.csr_rdat); end
        drive(0, 1, 0, 12'h340, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL trap_drops_write got %h exp 0", bus.csr_rdat); end
        drive(0, 0, 0, 12'h0, 0);
        mret_ena = 1; tick(); mret_ena = 0;
        drive(0, 1, 0, 12'h300, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h1888) begin err_cnt++; $display("FAIL mret_mstatus got %h exp 1888", bus.csr_rdat); end
    endtask

    task automatic test_vector();
        logic [31:0] exp_v;
        idle(); do_reset();
        drive(1, 0, 1, 12'h305, 32'h80000001); tick();
        drive(0, 1, 0, 12'h305, 0);
`ifdef CSR_VECTORED_EN
        exp_v = 32'h80000001;
`else
        exp_v = 32'h80000000;
`endif
        vec_cnt++; if (bus.csr_rdat !== exp_v) begin err_cnt++; $display("FAIL mtvec_read got %h exp %h", bus.csr_rdat, exp_v); end
        trap_cause = 32'h8000000B; #1;
`ifdef CSR_VECTORED_EN
        exp_v = 32'h8000002C;
`else
        exp_v = 32'h80000000;
`endif
        vec_cnt++; if (trap_tgt !== exp_v) begin err_cnt++; $display("FAIL tgt_irq got %h exp %h", trap_tgt, exp_v); end
        trap_cause = 32'h2; #1;
        vec_cnt++; if (trap_tgt !== 32'h80000000) begin err_cnt++; $display("FAIL tgt_exc got %h exp 80000000", trap_tgt); end
        drive(1, 0, 1, 12'h305, 32'h80000003); tick();
        trap_cause = 32'h8000000B; #1;
        vec_cnt++; if (trap_tgt !== 32'h80000000) begin err_cnt++; $display("FAIL tgt_mode1x got %h exp 80000000", trap_tgt); end
        idle();
    endtask

    task automatic test_counters();
        idle(); do_reset();
        drive(1, 0, 1, 12'hB80, 32'h5); tick();
        drive(1, 0, 1, 12'hB00, 32'hFFFFFFFF); tick();
        drive(0, 0, 0, 12'h0, 0); tick();
        drive(0, 1, 0, 12'hB00, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL mcycle_wrap_lo got %h exp 0", bus.csr_rdat); end
        tick(); drive(0, 1, 0, 12'hB80, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h6) begin err_cnt++; $display("FAIL mcycle_carry_hi got %h exp 6", bus.csr_rdat); end
        tick(); drive(1, 0, 1, 12'h320, 32'h1); tick();
        drive(0, 1, 0, 12'hB00, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h3) begin err_cnt++; $display("FAIL cy_freeze_a got %h exp 3", bus.csr_rdat); end
        tick(); tick();
        vec_cnt++; if (bus.csr_rdat !== 32'h3) begin err_cnt++; $display("FAIL cy_freeze_b got %h exp 3", bus.csr_rdat); end
        drive(0, 1, 0, 12'hB80, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h6) begin err_cnt++; $display("FAIL cy_freeze_hi got %h exp 6", bus.csr_rdat); end
        drive(1, 0, 1, 12'hFC0, 32'h1);
        vec_cnt++; if (bus.csr_ill !== 1'b1) begin err_cnt++; $display("FAIL ill_fc0 got %b exp 1", bus.csr_ill); end
        // high-half write discards the low-half carry
        idle(); do_reset();
        drive(1, 0, 1, 12'hB00, 32'hFFFFFFFF); tick();
        drive(1, 0, 1, 12'hB80, 32'h9); tick();
        drive(0, 1, 0, 12'hB80, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h9) begin err_cnt++; $display("FAIL hi_write_nocarry got %h exp 9", bus.csr_rdat); end
        drive(0, 1, 0, 12'hB00, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL hi_write_lo got %h exp 0", bus.csr_rdat); end
        // minstret 64-bit wrap
        drive(1, 0, 1, 12'hB82, 32'hFFFFFFFF); tick();
        drive(1, 0, 1, 12'hB02, 32'hFFFFFFFF); tick();
        drive(0, 1, 0, 12'hB02, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL minstret_hold got %h exp FFFFFFFF", bus.csr_rdat); end
        in_retr = 1; tick(); in_retr = 0;
        drive(0, 1, 0, 12'hB02, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL minstret_wrap_lo got %h exp 0", bus.csr_rdat); end
        drive(0, 1, 0, 12'hB82, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL minstret_wrap_hi got %h exp 0", bus.csr_rdat); end
        // hpm counter 4 on hpm_evt[1], then inhibited
        drive(0, 0, 0, 12'h0, 0);
        hpm_evt = 4'b0010; tick(); tick(); tick();
        drive(0, 1, 0, 12'hB04, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h3) begin err_cnt++; $display("FAIL hpm4_count got %h exp 3", bus.csr_rdat); end
        drive(1, 0, 1, 12'h320, 32'h10); tick(); tick(); tick();
        drive(0, 1, 0, 12'hB04, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h4) begin err_cnt++; $display("FAIL hpm4_inhibit got %h exp 4", bus.csr_rdat); end
        drive(0, 1, 0, 12'hB03, 0);
        vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL hpm3_idle got %h exp 0", bus.csr_rdat); end
        idle();
    endtask

    task automatic test_random();
        logic [11:0] pool [24];
        pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83,
                 12'hB06, 12'hB86, 12'hB01, 12'hB07, 12'hF13, 12'hF11, 12'h7C0, 12'hFC0};
        idle(); do_reset(); m_reset();
        for (int i = 0; i < 600; i++) begin
            logic [32:0] r;
            logic [31:0] er, pend, ec;
            logic        er_req;
            if (i == 300) begin
                // asynchronous reset while a write is still being driven
                rst_n = 0; #1;
                m_reset();
                drive(0, 1, 0, 12'h340, 0);
                vec_cnt++; if (bus.csr_rdat !== 32'h0) begin err_cnt++; $display("FAIL async_reset got %h exp 0", bus.csr_rdat); end
                do_reset();
            end
            trap_ena   = ($urandom_range(0, 15) == 0);
            mret_ena   = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom; trap_tval = $urandom; trap_pc = $urandom;
            ext_ip = 1'($urandom); tmr_ip = 1'($urandom); sft_ip = 1'($urandom);
            in_retr = 1'($urandom); hpm_evt = NHPM'($urandom);
            drive(1'($urandom), 1'($urandom), 2'($urandom), pool[$urandom_range(0, 23)],
                  ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom);
            r      = m_rd(bus.csr_idx);
            er     = (bus.csr_ren && r[32]) ? r[31:0] : 32'h0;
            pend   = m_mip() & m_mier;
            er_req = m_mie && (pend != 0);
            ec     = !er_req ? 32'h0 : pend[11] ? 32'h8000000B : pend[3] ? 32'h80000003 : 32'h80000007;
            vec_cnt++; if (bus.csr_rdat !== er || bus.csr_ill !== m_ill()) begin err_cnt++; $display("FAIL rnd_csr i=%0d idx %h got %h/%b exp %h/%b", i, bus.csr_idx, bus.csr_rdat, bus.csr_ill, er, m_ill()); end
            vec_cnt++; if (irq_req !== er_req || irq_cause !== ec) begin err_cnt++; $display("FAIL rnd_irq i=%0d got %b/%h exp %b/%h", i, irq_req, irq_cause, er_req, ec); end
            vec_cnt++; if (trap_tgt !== m_tgt() || cmepc !== m_mepc) begin err_cnt++; $display("FAIL rnd_trap i=%0d got %h/%h exp %h/%h", i, trap_tgt, cmepc, m_tgt(), m_mepc); end
            m_step();
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_rmw();
        test_illegal();
        test_irq();
        test_trap();
        test_vector();
        test_counters();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
